// File: rtl/gpio_multi_lut_scaler.sv
// Multi-channel signed LUT scaler for wide AXI-stream beats. Tables are loaded byte-serially
// over the PS GPIO word and the selected entry is read back on gpio_out.
module gpio_multi_lut_scaler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned LANES    = 16,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned OUT_W    = 16,
    parameter logic [15:0] REG_BASE = 16'h0100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     gpio_in,
    output logic [31:0]                     gpio_out,
    input  logic [NUM_CH*LANES*IN_W-1:0]    s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [NUM_CH*LANES*OUT_W-1:0]   m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);
    localparam int unsigned Depth = 2 ** IN_W;
    localparam int unsigned SelW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned Shift = OUT_W - IN_W;

    logic [24:0]             gpio_d1, gpio_d2;
    logic                    wclk_prev;
    logic                    wr_edge;
    logic [15:0]             wr_addr;
    logic [7:0]              wr_byte;

    logic [15:0]             addr_reg [NUM_CH];
    logic [15:0]             data_reg [NUM_CH];
    logic [NUM_CH-1:0]       byte_cnt;
    logic [NUM_CH-1:0]       bypass;
    logic [SelW-1:0]         rdsel;
    logic [15:0]             commit_cnt;
    logic [15:0]             rd_word;
    logic [OUT_W-1:0]        lut [NUM_CH][Depth];

    logic [NUM_CH-1:0]       addr_hit, data_hit;
    logic                    bypass_hit, rdsel_hit;
    logic                    commit;
    logic [SelW-1:0]         commit_ch;
    logic [IN_W-1:0]         commit_idx;
    logic [15:0]             commit_word;
    logic [OUT_W-1:0]        rd_entry;
    logic                    unused_bits;

    logic                    advance;
    logic                    st1_valid;
    logic [NUM_CH*LANES*IN_W-1:0]  st1_data;
    logic [NUM_CH*LANES*OUT_W-1:0] lookup;
    logic [IN_W-1:0]         code;

    assign wr_edge = gpio_d2[24] && !wclk_prev;
    assign wr_addr = gpio_d2[15:0];
    assign wr_byte = gpio_d2[23:16];

    always_comb begin
        addr_hit  = '0;
        data_hit  = '0;
        commit    = 1'b0;
        commit_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            addr_hit[c] = wr_edge && (wr_addr == REG_BASE + 16'(2 * c));
            data_hit[c] = wr_edge && (wr_addr == REG_BASE + 16'(2 * c + 1));
            if (data_hit[c] && byte_cnt[c]) begin
                commit    = 1'b1;
                commit_ch = SelW'(c);
            end
        end
        bypass_hit  = wr_edge && (wr_addr == REG_BASE + 16'(2 * NUM_CH));
        rdsel_hit   = wr_edge && (wr_addr == REG_BASE + 16'(2 * NUM_CH + 1));
        commit_word = {data_reg[commit_ch][7:0], wr_byte};
        commit_idx  = addr_reg[commit_ch][IN_W-1:0];
    end

    always_comb begin
        rd_entry = '0;
        if (32'(rdsel) < NUM_CH) begin
            rd_entry = lut[rdsel][addr_reg[rdsel][IN_W-1:0]];
        end
    end

    // High bytes of the shift registers only matter as the word shifts through.
    always_comb begin
        unused_bits = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            unused_bits = unused_bits ^ (^{addr_reg[c][15:8], data_reg[c][15:8]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_d1    <= '0;
            gpio_d2    <= '0;
            wclk_prev  <= 1'b0;
            byte_cnt   <= '0;
            bypass     <= '1;
            rdsel      <= '0;
            commit_cnt <= '0;
            rd_word    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                addr_reg[c] <= '0;
                data_reg[c] <= '0;
            end
        end else begin
            gpio_d1   <= gpio_in[24:0];
            gpio_d2   <= gpio_d1;
            wclk_prev <= gpio_d2[24];
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr_hit[c]) begin
                    addr_reg[c] <= {addr_reg[c][7:0], wr_byte};
                    byte_cnt[c] <= 1'b0;
                end
                if (data_hit[c]) begin
                    data_reg[c] <= {data_reg[c][7:0], wr_byte};
                    byte_cnt[c] <= ~byte_cnt[c];
                end
            end
            if (bypass_hit) bypass <= wr_byte[NUM_CH-1:0];
            if (rdsel_hit) rdsel <= wr_byte[SelW-1:0];
            if (commit) commit_cnt <= commit_cnt + 16'd1;
            rd_word <= 16'($signed(rd_entry));
        end
    end

    // Table storage is never reset; software must program it.
    always_ff @(posedge clk) begin
        if (commit) lut[commit_ch][commit_idx] <= commit_word[OUT_W-1:0];
    end

    assign gpio_out      = {commit_cnt, rd_word};
    assign advance       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = advance;

    // Zero-extending then shifting by OUT_W-IN_W equals sign-extend-and-shift.
    always_comb begin
        lookup = '0;
        code   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int l = 0; l < LANES; l++) begin
                code = st1_data[(c * LANES + l) * IN_W +: IN_W];
                if (bypass[c]) begin
                    lookup[(c * LANES + l) * OUT_W +: OUT_W] = OUT_W'(code) << Shift;
                end else begin
                    lookup[(c * LANES + l) * OUT_W +: OUT_W] = lut[c][code];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_valid     <= 1'b0;
            st1_data      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (advance) begin
            st1_valid     <= s_axis_tvalid;
            st1_data      <= s_axis_tdata;
            m_axis_tvalid <= st1_valid;
            m_axis_tdata  <= lookup;
        end
    end

endmodule
